// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-file widths and write-back arbiter state type
package cpu_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W = 32;
  typedef enum logic {NORMAL, DRAIN} arb_state_e;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: load-result queue with per-entry kill bits and live-address match vectors
module wb_fifo import cpu_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [REG_ADDR_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0]     push_data_i,
  input  logic                  pop_i,
  input  logic                  kill_i,
  input  logic [REG_ADDR_W-1:0] kill_addr_i,
  input  logic [REG_ADDR_W-1:0] q_rd1_i,
  input  logic [REG_ADDR_W-1:0] q_rd2_i,
  output logic [CW-1:0]         count_o,
  output logic [REG_ADDR_W-1:0] head_addr_o,
  output logic [DATA_W-1:0]     head_data_o,
  output logic                  head_kill_o,
  output logic [DEPTH-1:0]      match1_o,
  output logic [DEPTH-1:0]      match2_o
);
  logic [REG_ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0]     data_q [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d, kill_q, kill_d, kill_hit;
  logic [PW-1:0]         wr_q, rd_q;
  logic [CW-1:0]         count_q;
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    assign kill_hit[i] = valid_q[i] && addr_q[i] == kill_addr_i;
    assign match1_o[i] = valid_q[i] && !kill_q[i] && addr_q[i] == q_rd1_i;
    assign match2_o[i] = valid_q[i] && !kill_q[i] && addr_q[i] == q_rd2_i;
  end
  // The entry being pushed is younger than the killing ALU result, so push clears its kill bit last
  always_comb begin
    valid_d = valid_q;
    kill_d = kill_i ? kill_q | kill_hit : kill_q;
    if (pop_i) valid_d[rd_q] = 1'b0;
    if (push_i) begin
      valid_d[wr_q] = 1'b1;
      kill_d[wr_q] = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      kill_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      kill_q <= kill_d;
      wr_q <= wr_q + PW'(push_i);
      rd_q <= rd_q + PW'(pop_i);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end
  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_q[wr_q] <= push_addr_i;
      data_q[wr_q] <= push_data_i;
    end
  end
  assign count_o = count_q;
  assign head_addr_o = addr_q[rd_q];
  assign head_data_o = data_q[rd_q];
  assign head_kill_o = kill_q[rd_q];
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and queued load results onto one registered register-file write port
module wb_arbiter import cpu_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int DRAIN_EXIT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  input  logic [REG_ADDR_W-1:0] q_rd1,
  input  logic [REG_ADDR_W-1:0] q_rd2,
  output logic                  q_busy1,
  output logic                  q_busy2
);
  localparam int CW = $clog2(DEPTH) + 1;
  arb_state_e            state_q, state_d;
  logic [CW-1:0]         count, cnt_nx;
  logic                  alu_wr, push, pop, head_wr, head_kill;
  logic [REG_ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0]     head_data;
  logic [DEPTH-1:0]      match1, match2;
  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]     rf_wdata_q, rf_wdata_d;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset),
    .push_i(push), .push_addr_i(mem_addr), .push_data_i(mem_data),
    .pop_i(pop), .kill_i(alu_wr), .kill_addr_i(alu_addr),
    .q_rd1_i(q_rd1), .q_rd2_i(q_rd2),
    .count_o(count), .head_addr_o(head_addr), .head_data_o(head_data),
    .head_kill_o(head_kill), .match1_o(match1), .match2_o(match2)
  );
  assign alu_ready = state_q == NORMAL;
  assign mem_ready = count < CW'(DEPTH);
  assign alu_wr = alu_valid && alu_ready && alu_addr != '0;
  assign push = mem_valid && mem_ready && mem_addr != '0;
  // alu_wr never fires in DRAIN, so there the head pops every cycle
  assign pop = count != '0 && (head_kill || !alu_wr);
  assign head_wr = pop && !head_kill;
  always_comb begin
    cnt_nx = count + CW'(push) - CW'(pop);
    state_d = state_q == NORMAL ? (cnt_nx == CW'(DEPTH) ? DRAIN : NORMAL)
                                : (cnt_nx <= CW'(DRAIN_EXIT) ? NORMAL : DRAIN);
    rf_we_d = alu_wr || head_wr;
    rf_waddr_d = alu_wr ? alu_addr : head_wr ? head_addr : rf_waddr_q;
    rf_wdata_d = alu_wr ? alu_data : head_wr ? head_data : rf_wdata_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= NORMAL;
      rf_we_q <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      rf_we_q <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end
  assign rf_we = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign q_busy1 = q_rd1 != '0 && (|match1 || (rf_we_q && rf_waddr_q == q_rd1));
  assign q_busy2 = q_rd2 != '0 && (|match2 || (rf_we_q && rf_waddr_q == q_rd2));
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenario tests for wb_arbiter with DEPTH=4, DRAIN_EXIT=1
module tb_wb_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic alu_valid = 1'b0, mem_valid = 1'b0;
  logic alu_ready, mem_ready, rf_we, q_busy1, q_busy2;
  logic [4:0] alu_addr = '0, mem_addr = '0, rf_waddr, q_rd1 = '0, q_rd2 = '0;
  logic [31:0] alu_data = '0, mem_data = '0, rf_wdata;
  logic [4:0] log_a [$];
  logic [31:0] log_d [$];
  int checks = 0, errors = 0;

  wb_arbiter #(.DEPTH(4), .DRAIN_EXIT(1)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .q_rd1(q_rd1), .q_rd2(q_rd2), .q_busy1(q_busy1), .q_busy2(q_busy2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (rf_we === 1'b1) begin
      log_a.push_back(rf_waddr);
      log_d.push_back(rf_wdata);
    end
  end

  task automatic idle();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h33;
    mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 32'h44;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle();
    q_rd1 = 5'd3; q_rd2 = 5'd4;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", rf_we); end
    checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr got %0d exp 0", rf_waddr); end
    checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h exp 0", rf_wdata); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready got %b exp 1", alu_ready); end
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL reset_mem_ready got %b exp 1", mem_ready); end
    checks++; if (q_busy1 !== 1'b0 || q_busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b%b exp 00", q_busy1, q_busy2); end
    log_a.delete(); log_d.delete();
    repeat (4) @(negedge clk);
    checks++; if (log_a.size() != 0) begin errors++; $display("FAIL reset_dropped got %0d writes exp 0", log_a.size()); end
  endtask

  task automatic test_alu();
    log_a.delete(); log_d.delete();
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h11; q_rd1 = 5'd3;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL alu_ready got %b exp 1", alu_ready); end
    @(negedge clk);
    idle();
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h11}) begin errors++; $display("FAIL alu_write got we=%b a=%0d d=%h exp we=1 a=3 d=11", rf_we, rf_waddr, rf_wdata); end
    checks++; if (q_busy1 !== 1'b1) begin errors++; $display("FAIL alu_busy got %b exp 1", q_busy1); end
    @(negedge clk);
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd3, 32'h11}) begin errors++; $display("FAIL alu_hold got we=%b a=%0d d=%h exp we=0 a=3 d=11", rf_we, rf_waddr, rf_wdata); end
    checks++; if (q_busy1 !== 1'b0) begin errors++; $display("FAIL alu_busy_clear got %b exp 0", q_busy1); end
  endtask

  task automatic test_same_cycle();
    alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h5;
    mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 32'h6;
    q_rd2 = 5'd9;
    @(negedge clk);
    idle();
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'h5}) begin errors++; $display("FAIL same_alu got we=%b a=%0d d=%h exp we=1 a=9 d=5", rf_we, rf_waddr, rf_wdata); end
    checks++; if (q_busy2 !== 1'b1) begin errors++; $display("FAIL same_busy got %b exp 1", q_busy2); end
    @(negedge clk);
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'h6}) begin errors++; $display("FAIL same_load got we=%b a=%0d d=%h exp we=1 a=9 d=6", rf_we, rf_waddr, rf_wdata); end
    @(negedge clk);
    checks++; if (rf_we !== 1'b0 || q_busy2 !== 1'b0) begin errors++; $display("FAIL same_done got we=%b busy=%b exp 0 0", rf_we, q_busy2); end
  endtask

  task automatic test_r0();
    log_a.delete(); log_d.delete();
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h99;
    mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'h77;
    q_rd1 = 5'd0; q_rd2 = 5'd0;
    checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got %b%b exp 11", alu_ready, mem_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle();
      checks++; if (rf_we !== 1'b0 || q_busy1 !== 1'b0 || q_busy2 !== 1'b0) begin errors++; $display("FAIL r0_cycle%0d got we=%b busy=%b%b exp 0 00", i, rf_we, q_busy1, q_busy2); end
    end
    checks++; if (log_a.size() != 0) begin errors++; $display("FAIL r0_writes got %0d exp 0", log_a.size()); end
  endtask

  task automatic test_kill();
    logic [4:0] ea [4] = '{5'd6, 5'd6, 5'd7, 5'd8};
    logic [31:0] ed [4] = '{32'h60, 32'h60, 32'h2, 32'h8};
    logic [31:0] r7;
    log_a.delete(); log_d.delete();
    q_rd1 = 5'd7;
    alu_valid = 1'b1; alu_addr = 5'd6; alu_data = 32'h60;
    mem_valid = 1'b1; mem_addr = 5'd8; mem_data = 32'h8;
    @(negedge clk);
    mem_addr = 5'd7; mem_data = 32'h1;
    @(negedge clk);
    mem_valid = 1'b0;
    checks++; if (q_busy1 !== 1'b1) begin errors++; $display("FAIL kill_live_busy got %b exp 1", q_busy1); end
    alu_addr = 5'd7; alu_data = 32'h2;
    @(negedge clk);
    idle();
    @(negedge clk);
    checks++; if ({rf_we, rf_waddr} !== {1'b1, 5'd8}) begin errors++; $display("FAIL kill_head_write got we=%b a=%0d exp we=1 a=8", rf_we, rf_waddr); end
    checks++; if (q_busy1 !== 1'b0) begin errors++; $display("FAIL kill_busy got %b exp 0", q_busy1); end
    @(negedge clk);
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL kill_no_write got %b exp 0", rf_we); end
    repeat (2) @(negedge clk);
    checks++; if (log_a.size() != 4) begin errors++; $display("FAIL kill_count got %0d exp 4", log_a.size()); end
    r7 = 32'hx;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= log_a.size() || log_a[i] !== ea[i] || log_d[i] !== ed[i]) begin
        errors++;
        $display("FAIL kill_seq%0d got a=%0d d=%h exp a=%0d d=%h", i, i < log_a.size() ? log_a[i] : 5'bx, i < log_d.size() ? log_d[i] : 32'bx, ea[i], ed[i]);
      end
    end
    foreach (log_a[i]) if (log_a[i] == 5'd7) r7 = log_d[i];
    checks++; if (r7 !== 32'h2) begin errors++; $display("FAIL kill_final_r7 got %h exp 2", r7); end
  endtask

  task automatic test_back_to_back();
    q_rd1 = 5'd13;
    alu_valid = 1'b1; alu_addr = 5'd14; alu_data = 32'hE0;
    mem_valid = 1'b1; mem_addr = 5'd13; mem_data = 32'hD;
    @(negedge clk);
    mem_valid = 1'b0;
    alu_addr = 5'd13; alu_data = 32'hE1;
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd14, 32'hE0}) begin errors++; $display("FAIL b2b_0 got we=%b a=%0d d=%h exp we=1 a=14 d=e0", rf_we, rf_waddr, rf_wdata); end
    checks++; if (q_busy1 !== 1'b1) begin errors++; $display("FAIL b2b_busy_live got %b exp 1", q_busy1); end
    @(negedge clk);
    alu_addr = 5'd14; alu_data = 32'hE2;
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd13, 32'hE1}) begin errors++; $display("FAIL b2b_1 got we=%b a=%0d d=%h exp we=1 a=13 d=e1", rf_we, rf_waddr, rf_wdata); end
    @(negedge clk);
    idle();
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd14, 32'hE2}) begin errors++; $display("FAIL b2b_2 got we=%b a=%0d d=%h exp we=1 a=14 d=e2", rf_we, rf_waddr, rf_wdata); end
    checks++; if (q_busy1 !== 1'b0) begin errors++; $display("FAIL b2b_busy_killed got %b exp 0", q_busy1); end
    @(negedge clk);
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b exp 0", rf_we); end
  endtask

  task automatic test_drain();
    logic [4:0] la [4] = '{5'd5, 5'd10, 5'd11, 5'd12};
    logic [31:0] ld [4] = '{32'hAA, 32'hB1, 32'hB2, 32'hB3};
    logic [4:0] ea [9] = '{5'd6, 5'd6, 5'd6, 5'd6, 5'd5, 5'd10, 5'd11, 5'd6, 5'd12};
    logic [31:0] ed [9] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'hAA, 32'hB1, 32'hB2, 32'h100, 32'hB3};
    log_a.delete(); log_d.delete();
    alu_valid = 1'b1; alu_addr = 5'd6; alu_data = 32'h100;
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1'b1; mem_addr = la[i]; mem_data = ld[i];
      @(negedge clk);
    end
    mem_valid = 1'b0;
    checks++; if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin errors++; $display("FAIL drain_enter got alu_ready=%b mem_ready=%b exp 0 0", alu_ready, mem_ready); end
    repeat (2) @(negedge clk);
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL drain_hold got %b exp 0", alu_ready); end
    @(negedge clk);
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL drain_exit got %b exp 1", alu_ready); end
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
    checks++; if (log_a.size() != 9) begin errors++; $display("FAIL drain_count got %0d exp 9", log_a.size()); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (i >= log_a.size() || log_a[i] !== ea[i] || log_d[i] !== ed[i]) begin
        errors++;
        $display("FAIL drain_seq%0d got a=%0d d=%h exp a=%0d d=%h", i, i < log_a.size() ? log_a[i] : 5'bx, i < log_d.size() ? log_d[i] : 32'bx, ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_reset_flush();
    q_rd1 = 5'd16;
    alu_valid = 1'b1; alu_addr = 5'd20; alu_data = 32'h20;
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1'b1; mem_addr = 5'(16 + i); mem_data = 32'(i + 1);
      @(negedge clk);
    end
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL flush_full got %b exp 0", mem_ready); end
    reset = 1'b1;
    mem_addr = 5'd21;
    @(negedge clk);
    reset = 1'b0;
    idle();
    log_a.delete(); log_d.delete();
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd0, 32'd0}) begin errors++; $display("FAIL flush_rf got we=%b a=%0d d=%h exp 0 0 0", rf_we, rf_waddr, rf_wdata); end
    checks++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b%b exp 11", mem_ready, alu_ready); end
    checks++; if (q_busy1 !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp 0", q_busy1); end
    repeat (6) @(negedge clk);
    checks++; if (log_a.size() != 0) begin errors++; $display("FAIL flush_writes got %0d exp 0", log_a.size()); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_same_cycle();
    test_r0();
    test_kill();
    test_back_to_back();
    test_drain();
    test_reset_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
